// File: rtl/emif_pll_sim_pkg.sv
// Shared types and constants for the simulation-only EMIF PLL divider model.
package emif_pll_sim_pkg;

    localparam int MAX_CNTRS = 18;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        DPS_IDLE  = 2'd0,
        DPS_SHIFT = 2'd1,
        DPS_DONE  = 2'd2
    } dps_state_e;

    // Counter start value that places the first rising output PHASE cycles late.
    function automatic logic [CNT_W-1:0] cnt_init(input int div, input int phase);
        int r;
        if (div < 2) begin
            r = 0;
        end else begin
            r = (div - (phase % div)) % div;
        end
        return r[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/emif_pll_sim_cntr.sv
// One C-counter divider: free-runs modulo DIV once locked; hold/advance nudge its phase.
module emif_pll_sim_cntr
    import emif_pll_sim_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int PHASE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic locked_i,
    input  logic locked_nx_i,
    input  logic hold_i,
    input  logic adv_i,
    output logic clk_o
);

    if (DIV < 2 || DIV > 255) begin : g_bad_div
        $error("emif_pll_sim_cntr: divide ratio must be within 2..255");
    end

    localparam logic [CNT_W-1:0] INIT  = cnt_init(DIV, PHASE);
    localparam logic [CNT_W:0]   DIV_W = (CNT_W+1)'(DIV);
    localparam logic [CNT_W:0]   HALF  = (CNT_W+1)'(DIV / 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   sum_s;
    logic             clk_q, clk_d;

    // Next count and next output level.
    always_comb begin
        cnt_d = cnt_q;
        sum_s = {1'b0, cnt_q} + (adv_i ? (CNT_W+1)'(2) : (CNT_W+1)'(1));
        if (sum_s >= DIV_W) begin
            sum_s = sum_s - DIV_W;
        end else begin
            sum_s = sum_s;
        end
        if (!locked_i) begin
            cnt_d = INIT;
        end else if (hold_i) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = sum_s[CNT_W-1:0];
        end
        clk_d = locked_nx_i && ({1'b0, cnt_d} < HALF);
    end

    // Counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= INIT;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign clk_o = clk_q;

endmodule

// File: rtl/altera_emif_arch_nf_pll_div_sim.sv
// Behavioural PLL stand-in: lock timer plus NUM_CNTRS phased dividers.
// Dynamic phase shift is built only when EMIF_PLL_SIM_DPS_EN is defined.
module altera_emif_arch_nf_pll_div_sim
    import emif_pll_sim_pkg::*;
#(
    parameter int                         NUM_CNTRS     = 9,
    parameter logic [NUM_CNTRS*CNT_W-1:0] CNT_DIV_VEC   = {NUM_CNTRS{8'd4}},
    parameter logic [NUM_CNTRS*CNT_W-1:0] CNT_PHASE_VEC = {NUM_CNTRS{8'd0}},
    parameter int                         LOCK_CYCLES   = 32,
    parameter int                         PORT_DFT_NF_PLL_NUM_SHIFT_WIDTH = 3,
    localparam int                        CNTSEL_W      = $clog2(NUM_CNTRS)
) (
    input  logic                                       pll_ref_clk_int,
    input  logic                                       global_reset_n_int,
    output logic                                       pll_locked,
    output logic [NUM_CNTRS-1:0]                       pll_c_counters,
    input  logic                                       pll_phase_en,
    input  logic                                       pll_up_dn,
    input  logic [CNTSEL_W-1:0]                        pll_cnt_sel,
    input  logic [PORT_DFT_NF_PLL_NUM_SHIFT_WIDTH-1:0] pll_num_phase_shifts,
    output logic                                       pll_phase_done,
    output logic                                       pll_phase_err
);

    if (NUM_CNTRS < 2 || NUM_CNTRS > MAX_CNTRS || LOCK_CYCLES < 1 || LOCK_CYCLES > 255) begin : g_bad_cfg
        $error("altera_emif_arch_nf_pll_div_sim: NUM_CNTRS or LOCK_CYCLES out of range");
    end

    localparam int             NSW    = PORT_DFT_NF_PLL_NUM_SHIFT_WIDTH;
    localparam logic [7:0]     LOCK_N = 8'(LOCK_CYCLES);

    logic [7:0]           lock_cnt_q, lock_cnt_d;
    logic                 locked_q, locked_d;
    logic [NUM_CNTRS-1:0] hold_s, adv_s;

    // Saturating lock timer.
    always_comb begin
        if (lock_cnt_q < LOCK_N) begin
            lock_cnt_d = lock_cnt_q + 8'd1;
        end else begin
            lock_cnt_d = lock_cnt_q;
        end
        locked_d = (lock_cnt_d >= LOCK_N);
    end

    // Lock state registers.
    always_ff @(posedge pll_ref_clk_int or negedge global_reset_n_int) begin
        if (!global_reset_n_int) begin
            lock_cnt_q <= 8'd0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign pll_locked = locked_q;

`ifdef EMIF_PLL_SIM_DPS_EN
    dps_state_e          state_q, state_d;
    logic                en_q;
    logic                up_q, up_d;
    logic [CNTSEL_W-1:0] sel_q, sel_d;
    logic [NSW-1:0]      rem_q, rem_d;
    logic                done_q, done_d, err_q, err_d;
    logic                step_s;

    // Shift sequencer; an out-of-range select walks through SHIFT with nothing to do.
    always_comb begin
        state_d = state_q;
        up_d    = up_q;
        sel_d   = sel_q;
        rem_d   = rem_q;
        done_d  = done_q;
        err_d   = err_q;
        step_s  = 1'b0;
        case (state_q)
            DPS_IDLE: begin
                if (pll_phase_en && !en_q && locked_q) begin
                    sel_d  = pll_cnt_sel;
                    up_d   = pll_up_dn;
                    done_d = 1'b0;
                    if (32'(pll_cnt_sel) >= 32'(NUM_CNTRS)) begin
                        err_d   = 1'b1;
                        rem_d   = {NSW{1'b0}};
                        state_d = DPS_SHIFT;
                    end else if (pll_num_phase_shifts == {NSW{1'b0}}) begin
                        rem_d   = {NSW{1'b0}};
                        state_d = DPS_DONE;
                    end else begin
                        rem_d   = pll_num_phase_shifts;
                        state_d = DPS_SHIFT;
                    end
                end else begin
                    state_d = DPS_IDLE;
                end
            end
            DPS_SHIFT: begin
                step_s = (rem_q != {NSW{1'b0}});
                if (rem_q != {NSW{1'b0}}) begin
                    rem_d = rem_q - NSW'(1);
                end else begin
                    rem_d = rem_q;
                end
                if (rem_q <= NSW'(1)) begin
                    state_d = DPS_DONE;
                end else begin
                    state_d = DPS_SHIFT;
                end
            end
            DPS_DONE: begin
                state_d = DPS_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = DPS_IDLE;
                done_d  = 1'b1;
            end
        endcase
    end

    // Sequencer registers; reset throws away any shift in flight.
    always_ff @(posedge pll_ref_clk_int or negedge global_reset_n_int) begin
        if (!global_reset_n_int) begin
            state_q <= DPS_IDLE;
            en_q    <= 1'b0;
            up_q    <= 1'b0;
            sel_q   <= {CNTSEL_W{1'b0}};
            rem_q   <= {NSW{1'b0}};
            done_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= pll_phase_en;
            up_q    <= up_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    for (genvar i = 0; i < NUM_CNTRS; i++) begin : g_dps_sel
        assign hold_s[i] = step_s &  up_q & (32'(sel_q) == 32'(i));
        assign adv_s[i]  = step_s & ~up_q & (32'(sel_q) == 32'(i));
    end

    assign pll_phase_done = done_q;
    assign pll_phase_err  = err_q;
`else
    logic unused_dps_s;
    assign unused_dps_s   = ^{pll_phase_en, pll_up_dn, pll_cnt_sel, pll_num_phase_shifts};
    assign hold_s         = {NUM_CNTRS{1'b0}};
    assign adv_s          = {NUM_CNTRS{1'b0}};
    assign pll_phase_done = 1'b1;
    assign pll_phase_err  = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CNTRS; i++) begin : g_cntr
        emif_pll_sim_cntr #(
            .DIV   (int'(CNT_DIV_VEC[i*CNT_W +: CNT_W])),
            .PHASE (int'(CNT_PHASE_VEC[i*CNT_W +: CNT_W]))
        ) u_cntr (
            .clk         (pll_ref_clk_int),
            .rst_n       (global_reset_n_int),
            .locked_i    (locked_q),
            .locked_nx_i (locked_d),
            .hold_i      (hold_s[i]),
            .adv_i       (adv_s[i]),
            .clk_o       (pll_c_counters[i])
        );
    end

endmodule

// File: doc/altera_emif_arch_nf_pll_div_sim.md
ALTERA_EMIF_ARCH_NF_PLL_DIV_SIM -- requirements
Module: altera_emif_arch_nf_pll_div_sim

Interface
REQ-001 Parameter NUM_CNTRS, default 9: number of C-counter outputs, legal range 2..18.
REQ-002 Parameter CNT_DIV_VEC, default all 8'd4: packed NUM_CNTRS x 8-bit per-counter divide ratio in VCO cycles, legal 2..255; a value of 1 or 0 SHALL cause an elaboration error.
REQ-003 Parameter CNT_PHASE_VEC, default all 8'd0: packed NUM_CNTRS x 8-bit initial phase delay per counter, in VCO cycles.
REQ-004 Parameter LOCK_CYCLES, default 32: VCO cycles from reset release to lock, legal 1..255.
REQ-005 Parameter PORT_DFT_NF_PLL_NUM_SHIFT_WIDTH, default 3; localparam CNTSEL_W = $clog2(NUM_CNTRS).
REQ-006 pll_ref_clk_int  in  1  VCO-rate clock; the only clock.
REQ-007 global_reset_n_int  in  1  asynchronous active-low reset.
REQ-008 pll_locked  out  1  registered lock indication.
REQ-009 pll_c_counters  out  NUM_CNTRS  divided clock outputs, each registered.
REQ-010 pll_phase_en  in  1  dynamic phase shift (DPS) request, rising-edge sensitive.
REQ-011 pll_up_dn  in  1  1 = delay (up), 0 = advance (down).
REQ-012 pll_cnt_sel  in  CNTSEL_W  counter to shift.
REQ-013 pll_num_phase_shifts  in  PORT_DFT_NF_PLL_NUM_SHIFT_WIDTH  number of one-VCO-cycle steps.
REQ-014 pll_phase_done  out  1  high when idle, low while a shift is in progress.
REQ-015 pll_phase_err  out  1  sticky flag: out-of-range pll_cnt_sel seen.

Function
REQ-016 Lock counter SHALL count rising edges after reset release, saturating; pll_locked rises at the LOCK_CYCLES-th edge and stays high until reset.
REQ-017 Counter i SHALL hold cnt_i = (DIV_i - PHASE_i mod DIV_i) mod DIV_i while unlocked and increment modulo DIV_i every edge while locked.
REQ-018 pll_c_counters[i] SHALL be registered as locked_next AND (cnt_i_next < DIV_i/2, floor); odd divides are low-dominant by one cycle.
REQ-019 DPS FSM states: IDLE, SHIFT, DONE.
REQ-020 IDLE -> SHIFT on a sampled 0->1 transition of pll_phase_en while pll_locked = 1; sel, dir and count latched on that edge; pll_phase_done goes low on the same edge.
REQ-021 In SHIFT, each edge performs one step on the selected counter: up holds cnt for that edge; down adds 2 modulo DIV; the remaining count decrements.
REQ-022 SHIFT -> DONE when the remaining count reaches 0; DONE -> IDLE on the next edge with pll_phase_done = 1.
REQ-023 A latched count of 0 SHALL go IDLE -> DONE -> IDLE with no step taken.
REQ-024 A latched sel >= NUM_CNTRS SHALL set pll_phase_err, perform no step, and still complete the done handshake.
REQ-025 pll_phase_en edges outside IDLE, or while unlocked, SHALL be ignored; a level held high SHALL trigger only one shift.

Reset
REQ-026 On global_reset_n_int = 0, asynchronously: pll_locked = 0, pll_c_counters = 0, pll_phase_done = 1, pll_phase_err = 0, FSM = IDLE, counters at their REQ-017 initial values.
REQ-027 Reset mid-shift SHALL abandon the shift; the phase accumulated by DPS is discarded.

Configuration
REQ-028 With EMIF_PLL_SIM_DPS_EN defined, REQ-019..025 are present.
REQ-029 Without EMIF_PLL_SIM_DPS_EN, the FSM is absent, the DPS inputs are ignored, pll_phase_done is tied to 1 and pll_phase_err is tied to 0.

Structure
REQ-030 Package emif_pll_sim_pkg SHALL hold the DPS state enum, MAX_CNTRS = 18 and CNT_W = 8.
REQ-031 Sub-module emif_pll_sim_cntr SHALL implement one divider with hold/advance inputs; it is instantiated NUM_CNTRS times via generate.

Verification (NUM_CNTRS=3, DIV={4,6,5}, PHASE={0,0,2}, LOCK_CYCLES=32)
REQ-032 Release reset -> pll_locked rises at edge 32; all pll_c_counters = 0 before that edge.
REQ-033 After lock -> c[0] period 4 (2 high / 2 low), c[1] period 6, c[2] period 5 (2 high / 3 low) with its first rise 2 cycles after lock.
REQ-034 sel=1, up=1, num=3, pulse phase_en -> phase_done low for 4 edges; c[1] rise delayed 3 cycles relative to c[0].
REQ-035 sel=3 -> pll_phase_err = 1 (sticky), phase_done low for 2 edges, no output phase change.
REQ-036 Reset asserted during SHIFT -> immediately phase_done = 1, locked = 0, outputs 0; relock at edge 32 with original phases.
REQ-037 Macro undefined, phase_en toggled -> phase_done constantly 1, output phases unchanged.
